// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage ALU: operation codes,
// ALUOp values from the main decoder and the ALU sequencing states.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } alu_state_t;

    localparam logic [1:0] ALUOP_MEM  = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_R    = 2'b10;
    localparam logic [1:0] ALUOP_RSVD = 2'b11;

    function automatic logic is_shift_op(input alu_ctrl_t ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational ALU control decode; also used by the branch-compare path.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic [6:0] op,
    output alu_ctrl_t  alu_ctrl
);

    // Only bit 5 of funct7/op distinguishes operations.
    logic unused_bits;
    assign unused_bits = ^{funct7[6], funct7[4:0], op[6], op[4:0]};

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_MEM, ALUOP_RSVD: alu_ctrl = ALU_ADD;
            ALUOP_BR:              alu_ctrl = ALU_SUB;
            ALUOP_R: begin
                case (funct3)
                    3'b000:  alu_ctrl = ({op[5], funct7[5]} == 2'b11) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_ctrl = ALU_SLL;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b011:  alu_ctrl = ALU_SLTU;
                    3'b100:  alu_ctrl = ALU_XOR;
                    3'b101:  alu_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_ctrl = ALU_OR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_unit.sv
// Handshaked execute-stage ALU with a registered result; shifts run iteratively,
// moving at most SHIFT_STEP bit positions per cycle.
module alu_unit
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [6:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [3:0]      alu_ctrl
);

    localparam int SHW = $clog2(XLEN);
    // Shift distances of XLEN or more never occur, so cap the candidate set.
    localparam int NCAND = (SHIFT_STEP < XLEN) ? SHIFT_STEP : XLEN - 1;
    localparam logic [SHW:0] STEP_W = (SHW + 1)'(SHIFT_STEP);

    alu_state_t      state_reg, state_next;
    alu_ctrl_t       ctrl_reg, ctrl_next;
    logic [XLEN-1:0] result_reg, result_next;
    logic            zero_reg, zero_next;
    logic [XLEN-1:0] work_reg, work_next;
    logic [SHW-1:0]  rem_reg, rem_next;

    alu_ctrl_t       dec_ctrl;
    logic [XLEN-1:0] alu_res;
    logic [SHW-1:0]  shamt;
    logic [SHW-1:0]  step_d;
    logic            last_step;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] cand [1:NCAND];
    logic            load;

    alu_ctrl_decode u_decode (
        .alu_op   (alu_op),
        .funct3   (funct3),
        .funct7   (funct7),
        .op       (op),
        .alu_ctrl (dec_ctrl)
    );

    assign shamt     = src_b[SHW-1:0];
    assign last_step = ({1'b0, rem_reg} <= STEP_W);
    assign step_d    = last_step ? rem_reg : STEP_W[SHW-1:0];

    generate
        for (genvar gi = 1; gi <= NCAND; gi++) begin : g_cand
            assign cand[gi] = (ctrl_reg == ALU_SLL) ? (work_reg << gi) :
                              (ctrl_reg == ALU_SRA) ? $unsigned($signed(work_reg) >>> gi) :
                                                      (work_reg >> gi);
        end
    endgenerate

    always_comb begin
        shifted = work_reg;
        for (int i = 1; i <= NCAND; i++) begin
            if (step_d == SHW'(i)) shifted = cand[i];
        end
    end

    // Shift ops only reach this path with shamt==0, where the result is src_a.
    always_comb begin
        alu_res = src_a;
        case (dec_ctrl)
            ALU_ADD:  alu_res = src_a + src_b;
            ALU_SUB:  alu_res = src_a - src_b;
            ALU_AND:  alu_res = src_a & src_b;
            ALU_OR:   alu_res = src_a | src_b;
            ALU_XOR:  alu_res = src_a ^ src_b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            default:  alu_res = src_a;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        ctrl_next   = ctrl_reg;
        result_next = result_reg;
        zero_next   = zero_reg;
        work_next   = work_reg;
        rem_next    = rem_reg;
        load        = 1'b0;

        case (state_reg)
            ST_IDLE: load = in_valid;
            ST_SHIFT: begin
                if (last_step) begin
                    result_next = shifted;
                    zero_next   = (shifted == '0);
                    rem_next    = '0;
                    state_next  = ST_DONE;
                end else begin
                    work_next = shifted;
                    rem_next  = rem_reg - step_d;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                    load       = in_valid;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (load) begin
            ctrl_next = dec_ctrl;
            if (is_shift_op(dec_ctrl) && (shamt != '0)) begin
                work_next  = src_a;
                rem_next   = shamt;
                state_next = ST_SHIFT;
            end else begin
                result_next = alu_res;
                zero_next   = (alu_res == '0);
                state_next  = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            ctrl_reg   <= ALU_ADD;
            result_reg <= '0;
            zero_reg   <= 1'b1;
            work_reg   <= '0;
            rem_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            ctrl_reg   <= ctrl_next;
            result_reg <= result_next;
            zero_reg   <= zero_next;
            work_reg   <= work_next;
            rem_reg    <= rem_next;
        end
    end

    assign in_ready  = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
    assign out_valid = (state_reg == ST_DONE);
    assign result    = result_reg;
    assign zero      = zero_reg;
    assign alu_ctrl  = ctrl_reg;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed cases plus randomized ops against
// an arithmetic reference model.
module tb_alu_unit;

    localparam int XLEN = 32;
    localparam int STEP = 4;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [6:0]      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic [3:0]      alu_ctrl;

    int n_checks = 0;
    int n_fails  = 0;

    alu_unit #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct3    (funct3),
        .funct7    (funct7),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .alu_ctrl  (alu_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: operation code, result and latency straight from the ISA rules.
    function automatic void model(input logic [1:0] aop, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [6:0] opc,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [3:0] ctrl, output logic [31:0] res,
                                  output int lat);
        int s;
        s = int'(b[4:0]);
        if (aop == 2'd1) ctrl = 4'd1;
        else if (aop != 2'd2) ctrl = 4'd0;
        else begin
            case (f3)
                3'd0: ctrl = (opc[5] && f7[5]) ? 4'd1 : 4'd0;
                3'd1: ctrl = 4'd7;
                3'd2: ctrl = 4'd5;
                3'd3: ctrl = 4'd6;
                3'd4: ctrl = 4'd4;
                3'd5: ctrl = f7[5] ? 4'd9 : 4'd8;
                3'd6: ctrl = 4'd3;
                default: ctrl = 4'd2;
            endcase
        end
        case (ctrl)
            4'd0: res = a + b;
            4'd1: res = a - b;
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: res = (a < b) ? 32'd1 : 32'd0;
            4'd7: res = a << s;
            4'd8: res = a >> s;
            default: res = $unsigned($signed(a) >>> s);
        endcase
        if (ctrl >= 4'd7 && s != 0) lat = 1 + (s + STEP - 1) / STEP;
        else lat = 1;
    endfunction

    task automatic scramble_inputs();
        alu_op = 2'($urandom);
        funct3 = 3'($urandom);
        funct7 = 7'($urandom);
        op     = 7'($urandom);
        src_a  = $urandom;
        src_b  = $urandom;
    endtask

    // One transaction: accept, wait for result, hold under backpressure, release.
    task automatic run_op(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [6:0] opc, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        logic [3:0]  e_ctrl;
        logic [31:0] e_res;
        int          e_lat;
        int          cyc;
        model(aop, f3, f7, opc, a, b, e_ctrl, e_res, e_lat);
        @(negedge clk);
        out_ready = 1'b0;
        check("in_ready_idle", 64'(in_ready), 64'd1);
        alu_op = aop; funct3 = f3; funct7 = f7; op = opc; src_a = a; src_b = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble_inputs();
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 64) begin
            check("in_ready_shift", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", 64'(cyc), 64'(e_lat));
        check("result", 64'(result), 64'(e_res));
        check("zero", 64'(zero), 64'(e_res == 32'd0));
        check("alu_ctrl", 64'(alu_ctrl), 64'(e_ctrl));
        $display("op aop=%0d f3=%0d f7=%02h op=%02h a=%08h b=%08h -> res=%08h ctrl=%0d lat=%0d",
                 aop, f3, f7, opc, a, b, result, alu_ctrl, cyc);
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk);
                #1;
                scramble_inputs();
            end
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_result", 64'(result), 64'(e_res));
            check("hold_zero", 64'(zero), 64'(e_res == 32'd0));
            check("hold_ctrl", 64'(alu_ctrl), 64'(e_ctrl));
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("after_handshake_valid", 64'(out_valid), 64'd0);
    endtask

    // Stream of non-shift ops with out_ready high: one result per cycle.
    task automatic back_to_back(input int n);
        logic [1:0]  q_aop [$];
        logic [2:0]  q_f3  [$];
        logic [6:0]  q_f7  [$];
        logic [6:0]  q_op  [$];
        logic [31:0] q_a   [$];
        logic [31:0] q_b   [$];
        logic [3:0]  e_ctrl;
        logic [31:0] e_res;
        int          e_lat;
        int          pick;
        for (int i = 0; i < n; i++) begin
            logic [2:0] f3_opts [6] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
            pick = int'($urandom_range(0, 5));
            q_aop.push_back(2'($urandom));
            q_f3.push_back(f3_opts[pick]);
            q_f7.push_back(7'($urandom));
            q_op.push_back(7'($urandom));
            q_a.push_back($urandom);
            q_b.push_back(($urandom_range(0, 3) == 0) ? q_a[i] : $urandom);
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alu_op = q_aop[0]; funct3 = q_f3[0]; funct7 = q_f7[0]; op = q_op[0];
        src_a = q_a[0]; src_b = q_b[0];
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            model(q_aop[i], q_f3[i], q_f7[i], q_op[i], q_a[i], q_b[i], e_ctrl, e_res, e_lat);
            check("b2b_valid", 64'(out_valid), 64'd1);
            check("b2b_in_ready", 64'(in_ready), 64'd1);
            check("b2b_result", 64'(result), 64'(e_res));
            check("b2b_ctrl", 64'(alu_ctrl), 64'(e_ctrl));
            $display("b2b #%0d a=%08h b=%08h -> res=%08h ctrl=%0d", i, q_a[i], q_b[i], result, alu_ctrl);
            if (i < n - 1) begin
                alu_op = q_aop[i+1]; funct3 = q_f3[i+1]; funct7 = q_f7[i+1]; op = q_op[i+1];
                src_a = q_a[i+1]; src_b = q_b[i+1];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("b2b_drain", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        scramble_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_zero", 64'(zero), 64'd1);
        check("rst_ctrl", 64'(alu_ctrl), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        // Register SUB versus immediate form (always ADD)
        run_op(2'b10, 3'b000, 7'h20, 7'h33, 32'd5, 32'd7, 0);
        run_op(2'b10, 3'b000, 7'h20, 7'h13, 32'd5, 32'd7, 0);
        // Shifts
        run_op(2'b10, 3'b101, 7'h20, 7'h33, 32'h8000_0000, 32'd9, 0);
        run_op(2'b10, 3'b001, 7'h00, 7'h33, 32'h1234_5678, 32'hFFFF_FFE0, 0);
        run_op(2'b10, 3'b101, 7'h00, 7'h33, 32'h8000_0000, 32'd31, 0);
        run_op(2'b10, 3'b001, 7'h00, 7'h13, 32'hDEAD_BEEF, 32'd4, 0);
        // Backpressure
        run_op(2'b00, 3'b000, 7'h00, 7'h03, 32'h1000, 32'h0234, 5);
        // Compare and zero flag
        run_op(2'b10, 3'b010, 7'h00, 7'h33, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(2'b10, 3'b011, 7'h00, 7'h33, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(2'b01, 3'b000, 7'h00, 7'h63, 32'hCAFE_F00D, 32'hCAFE_F00D, 2);

        back_to_back(8);

        // Reset in the middle of a long shift
        @(negedge clk);
        alu_op = 2'b10; funct3 = 3'b001; funct7 = 7'h00; op = 7'h33;
        src_a = 32'hFFFF_FFFF; src_b = 32'd20;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("shift_busy", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_zero", 64'(zero), 64'd1);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_ctrl", 64'(alu_ctrl), 64'd0);
        repeat (6) begin
            @(posedge clk);
            #1;
            check("midrst_stays_idle", 64'(out_valid), 64'd0);
        end
        run_op(2'b00, 3'b000, 7'h00, 7'h03, 32'd100, 32'd23, 0);

        // Randomized transactions, including shifts with junk upper shamt bits
        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            run_op(2'($urandom), 3'($urandom), 7'($urandom), 7'($urandom), ra, rb,
                   int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
# alu_unit

Parametrised, handshaked ALU stage that succeeds the combinational ALU decoder of the pipelined core. It decodes ALUOp/funct3/funct7/op into the full RV32I integer operation set and executes it with a registered result. Shifts use an iterative barrel-free shifter, configurable in bits per cycle. The block sits in the execute stage between the ID/EX register and the EX/MEM register, with valid/ready handshakes on both sides.

## Interface
- XLEN, 32, datapath width; power of two, ≥ 8
- SHIFT_STEP, 1, maximum shift distance per cycle; power of two, 1..XLEN
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  operands/control valid
- in_ready  out  1  block can accept
- alu_op  in  2  ALUOp from main decoder
- funct3  in  3  instruction funct3
- funct7  in  7  instruction funct7
- op  in  7  instruction opcode
- src_a  in  XLEN  operand A
- src_b  in  XLEN  operand B (register or immediate)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- result  out  XLEN  registered result
- zero  out  1  result == 0 (for branches)
- alu_ctrl  out  4  decoded operation of the held result
- One clock; reset is synchronous and active-high (`clk`, `rst`).

## Operation
- Decode, combinational on the inputs:
  - alu_op 00 → ADD
  - alu_op 01 → SUB
  - alu_op 11 → ADD
  - alu_op 10, selected by funct3:
    - 000 → SUB if {op[5],funct7[5]}==11, else ADD
    - 001 → SLL
    - 010 → SLT
    - 011 → SLTU
    - 100 → XOR
    - 101 → SRA if funct7[5], else SRL
    - 110 → OR
    - 111 → AND
- alu_ctrl encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001. The low codes match the legacy 3-bit encoding zero-extended.
- Arithmetic:
  - ADD and SUB wrap modulo 2^XLEN.
  - SLT and SLTU return 1 or 0 in bit 0, upper bits zero.
  - shamt = src_b[log2(XLEN)-1:0]; the upper bits of src_b are ignored.
  - SRA replicates the sign bit of src_a.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, on accept: a non-shift op, or a shift with shamt==0, loads result and goes to DONE. A shift with shamt>0 loads the work register with src_a, sets rem=shamt, and goes to SHIFT.
  - SHIFT, each cycle: shift by d=min(rem,SHIFT_STEP) in the decoded direction, and set rem -= d. When rem ≤ SHIFT_STEP, go to DONE with the final value in result.
  - DONE: hold result, zero and alu_ctrl stable while out_ready=0. On out_ready=1, go to IDLE, or load the next op directly if a new input is accepted in the same cycle.
- in_ready = (state==IDLE) | (state==DONE & out_ready). in_ready is low throughout SHIFT.
- out_valid = (state==DONE).
- Reset, including mid-SHIFT: state IDLE, out_valid 0, result 0, zero 1, alu_ctrl 0000, rem 0, work register 0. In-flight work is discarded.

## Timing
- Non-shift op, or shift with shamt 0: accepted at edge k; out_valid high after edge k (latency 1).
- Shift with shamt s>0: out_valid high after edge k+ceil(s/SHIFT_STEP) (latency 1+ceil(s/SHIFT_STEP) cycles).
- Throughput: with out_ready held high, non-shift ops sustain one per cycle. A shift blocks input for ceil(s/SHIFT_STEP) cycles.
- Inputs are sampled only on the accept edge. Changes on the inputs at any other time have no effect.
- Backpressure: result is never overwritten while out_valid=1 and out_ready=0.

## Structure
- Package `alu_pkg`: alu_ctrl_t enum (4-bit, encodings above), state enum, ALUOp constants (ALUOP_MEM, ALUOP_BR, ALUOP_R, ALUOP_RSVD).
- Sub-module `alu_ctrl_decode`: the pure combinational decode (alu_op, funct3, funct7, op → alu_ctrl_t). It is shared with the branch-compare path.
- Top-level file: FSM, work register, rem counter, result mux.

## Test plan
- ADD/SUB: alu_op=10, funct3=000, op=0110011, funct7=0100000, src_a=5, src_b=7 → result 0xFFFFFFFE, alu_ctrl 0001, out_valid one cycle after accept. Repeat with op=0010011 → result 12 (ADD; immediate form has no SUB).
- Back-to-back: three non-shift ops with out_ready=1 → three results on consecutive cycles. in_ready stays high throughout.
- Shifts with SHIFT_STEP=4:
  - SRA src_a=0x80000000, shamt 9 → 0xFFC00000 with latency 4.
  - SLL shamt 0 → latency 1, result=src_a.
  - SRL shamt 31 → 1 with latency 9.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → result, zero and alu_ctrl unchanged and in_ready low. Release → handshake completes in that cycle.
- Compare/zero: SLT −1 vs 1 → result 1. SLTU 0xFFFFFFFF vs 1 → result 0, zero 1. alu_op=01 with src_a=src_b → zero 1.
- Reset mid-SHIFT (SHIFT_STEP=1, shamt 20, assert rst at cycle 5) → next cycle out_valid 0, result 0, zero 1, in_ready 1. A new ADD issued afterwards completes normally.
